addsub_digit_serial: RTL and testbench

//  Parametrised, digit-serial two's-complement adder/subtractor; next generation of the team's 8-bit ripple AdderSub.

---
 rtl/addsub_digit_serial.sv | 124 ++++++++++++
 tb/tb_addsub_digit_serial.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/addsub_digit_serial.sv
// Digit-serial two's-complement adder/subtractor, DIGIT bits per cycle.
// Define ADDSUB_OVF_EN to add the registered signed-overflow output.
module addsub_digit_serial #(
  parameter int WIDTH = 32,
  parameter int DIGIT = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] C,
  output logic             carry_borrow_out
`ifdef ADDSUB_OVF_EN
  ,
  output logic             overflow
`endif
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] bx_q;
  logic [WIDTH-1:0] work_q;
  logic [WIDTH-1:0] work_d;
  logic [WIDTH-1:0] c_q;
  logic             carry_q;
  logic             cbo_q;
  logic [CW-1:0]    cnt_q;
  logic [DIGIT-1:0] a_sl;
  logic [DIGIT-1:0] b_sl;
  logic [DIGIT:0]   sum;
  logic             accept;
  logic             last;
  int               base;

  assign accept = in_valid && (state_q == IDLE);
  assign last   = (cnt_q == CW'(NDIG - 1));

  always_comb begin
    base   = int'(cnt_q) * DIGIT;
    a_sl   = a_q[base +: DIGIT];
    b_sl   = bx_q[base +: DIGIT];
    sum    = {1'b0, a_sl} + {1'b0, b_sl}
           + {{DIGIT{1'b0}}, carry_q};
    work_d = work_q;
    work_d[base +: DIGIT] = sum[DIGIT-1:0];
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (accept) state_d = RUN;
      RUN:  if (last) state_d = DONE;
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      bx_q    <= '0;
      work_q  <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      c_q     <= '0;
      cbo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        a_q     <= A;
        bx_q    <= B ^ {WIDTH{mode}};
        carry_q <= mode;
        cnt_q   <= '0;
        work_q  <= '0;
      end else if (state_q == RUN) begin
        work_q  <= work_d;
        carry_q <= sum[DIGIT];
        cnt_q   <= cnt_q + CW'(1);
        // result registers change only on the final digit
        if (last) begin
          c_q   <= work_d;
          cbo_q <= sum[DIGIT];
        end
      end
    end
  end

`ifdef ADDSUB_OVF_EN
  logic ovf_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else if (state_q == RUN && last) begin
      ovf_q <= (a_q[WIDTH-1] == bx_q[WIDTH-1])
            && (sum[DIGIT-1] != a_q[WIDTH-1]);
    end
  end

  assign overflow = ovf_q;
`endif

  assign in_ready         = (state_q == IDLE);
  assign out_valid        = (state_q == DONE);
  assign C                = c_q;
  assign carry_borrow_out = cbo_q;

endmodule

// File: tb/tb_addsub_digit_serial.sv
// Bench for addsub_digit_serial at DIGIT = 8, 1 and WIDTH.
// Random and directed ops checked against an integer A+/-B model.
module tb_addsub_digit_serial;

  localparam longint SMAX = 64'sd2147483647;
  localparam longint SMIN = -64'sd2147483648;

  logic        clk;
  logic        rst;
  logic        in_valid  [3];
  logic        in_ready  [3];
  logic [31:0] a_in      [3];
  logic [31:0] b_in      [3];
  logic        mode      [3];
  logic        out_valid [3];
  logic        out_ready [3];
  logic [31:0] c_out     [3];
  logic        cbo       [3];
`ifdef ADDSUB_OVF_EN
  logic        ovf       [3];
`endif

  int n_chk;
  int n_pass;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int DG = (g == 0) ? 8 : (g == 1) ? 1 : 32;
    addsub_digit_serial #(
      .WIDTH(32),
      .DIGIT(DG)
    ) dut (
      .clk             (clk),
      .rst             (rst),
      .in_valid        (in_valid[g]),
      .in_ready        (in_ready[g]),
      .A               (a_in[g]),
      .B               (b_in[g]),
      .mode            (mode[g]),
      .out_valid       (out_valid[g]),
      .out_ready       (out_ready[g]),
      .C               (c_out[g]),
      .carry_borrow_out(cbo[g])
`ifdef ADDSUB_OVF_EN
      ,
      .overflow        (ovf[g])
`endif
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int nd(input int k);
    case (k)
      0:       return 4;
      1:       return 32;
      default: return 1;
    endcase
  endfunction

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic do_op(input int k,
                       input logic [31:0] a,
                       input logic [31:0] b,
                       input logic m,
                       input int hold);
    logic [32:0] s;
    longint      sa;
    longint      sb;
    longint      sr;
    logic        eov;
    int          lat;
    s   = {1'b0, a} + (m ? {1'b0, ~b} + 33'd1 : {1'b0, b});
    sa  = $signed(a);
    sb  = $signed(b);
    sr  = m ? sa - sb : sa + sb;
    eov = (sr > SMAX) || (sr < SMIN);
    check("in_ready", 64'(in_ready[k]), 64'd1);
    in_valid[k] = 1'b1;
    a_in[k]     = a;
    b_in[k]     = b;
    mode[k]     = m;
    @(posedge clk); #1;
    in_valid[k] = 1'b0;
    a_in[k]     = $urandom;
    b_in[k]     = $urandom;
    mode[k]     = ~m;
    lat = 0;
    while (!out_valid[k] && lat < 64) begin
      @(posedge clk); #1;
      lat++;
    end
    check("latency", 64'(lat), 64'(nd(k)));
    check("C", 64'(c_out[k]), 64'(s[31:0]));
    check("cbo", 64'(cbo[k]), 64'(s[32]));
`ifdef ADDSUB_OVF_EN
    check("ovf", 64'(ovf[k]), 64'(eov));
`endif
    for (int i = 0; i < hold; i++) begin
      in_valid[k] = 1'b1;
      a_in[k]     = $urandom;
      @(posedge clk); #1;
      check("hold_valid", 64'(out_valid[k]), 64'd1);
      check("hold_busy", 64'(in_ready[k]), 64'd0);
      check("hold_C", 64'(c_out[k]), 64'(s[31:0]));
      check("hold_cbo", 64'(cbo[k]), 64'(s[32]));
    end
    out_ready[k] = 1'b1;
    in_valid[k]  = (hold > 0);
    @(posedge clk); #1;
    out_ready[k] = 1'b0;
    in_valid[k]  = 1'b0;
    check("back_idle", 64'(in_ready[k]), 64'd1);
    check("back_nov", 64'(out_valid[k]), 64'd0);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h7FFF_FFFF;
      3:       return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    n_chk  = 0;
    n_pass = 0;
    rst    = 1'b1;
    for (int k = 0; k < 3; k++) begin
      in_valid[k]  = 1'b0;
      out_ready[k] = 1'b0;
      a_in[k]      = '0;
      b_in[k]      = '0;
      mode[k]      = 1'b0;
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check("rst_ready", 64'(in_ready[k]), 64'd1);
      check("rst_valid", 64'(out_valid[k]), 64'd0);
      check("rst_C", 64'(c_out[k]), 64'd0);
      check("rst_cbo", 64'(cbo[k]), 64'd0);
    end

    do_op(0, 32'h0000_00FF, 32'h1, 1'b0, 0);
    do_op(0, 32'd5, 32'd7, 1'b1, 0);
    do_op(0, 32'd7, 32'd5, 1'b1, 0);
    do_op(0, 32'h7FFF_FFFF, 32'h1, 1'b0, 0);
    do_op(0, 32'hFFFF_FFFF, 32'h1, 1'b0, 10);

    // abort an op mid-flight after a nonzero result is held
    do_op(0, 32'h1234_5678, 32'h1111_1111, 1'b0, 0);
    in_valid[0] = 1'b1;
    a_in[0]     = 32'hDEAD_BEEF;
    b_in[0]     = 32'h1;
    @(posedge clk); #1;
    in_valid[0] = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_ready", 64'(in_ready[0]), 64'd1);
    check("abort_valid", 64'(out_valid[0]), 64'd0);
    check("abort_C", 64'(c_out[0]), 64'd0);
    check("abort_cbo", 64'(cbo[0]), 64'd0);
    do_op(0, 32'h0000_0010, 32'h0000_0020, 1'b1, 0);

    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 40; i++) begin
        do_op(k, pick(), pick(), 1'($urandom_range(0, 1)),
              ($urandom_range(0, 3) == 0) ? 2 : 0);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
